vid_fetch: RTL and testbench

//  Video-side initiator for the mem_switch vid_* read port: walks a framebuffer from base_addr_i,

---
 rtl/vid_fetch.sv | 193 +++++++++++++++++++
 tb/tb_vid_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_fetch.sv
// rtl/vid_fetch.sv - framebuffer burst read initiator with FWFT pixel FIFO.
// Optional sticky underrun detection is built when VID_FETCH_UNDERRUN_EN is defined.
module vid_fetch #(
    parameter int WIDTH     = 32,
    parameter int ADDRESS   = 21,
    parameter int BURSTLOG2 = 2,
    parameter int FIFOLOG2  = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               frame_start_i,
    input  logic [ADDRESS-1:0] base_addr_i,
    input  logic [ADDRESS-1:0] frame_words_i,
    output logic               busy_o,
    output logic               vid_read_o,
    input  logic               vid_rack_i,
    input  logic               vid_ready_i,
    output logic [ADDRESS-1:0] vid_addr_o,
    input  logic [WIDTH-1:0]   vid_data_i,
    input  logic               pix_read_i,
    output logic [WIDTH-1:0]   pix_data_o,
    output logic               pix_empty_o,
    output logic               pix_underrun_o
);

    localparam int BURST = 1 << BURSTLOG2;
    localparam int DEPTH = 1 << FIFOLOG2;
    localparam logic [FIFOLOG2:0]    DEPTH_C   = (FIFOLOG2+1)'(DEPTH);
    localparam logic [FIFOLOG2:0]    BURST_C   = (FIFOLOG2+1)'(BURST);
    localparam logic [FIFOLOG2:0]    ONE_C     = (FIFOLOG2+1)'(1);
    localparam logic [ADDRESS-1:0]   BURST_A   = ADDRESS'(BURST);
    localparam logic [BURSTLOG2-1:0] LAST_BEAT = BURSTLOG2'(BURST-1);
    localparam logic [FIFOLOG2-1:0]  PTR_ONE   = FIFOLOG2'(1);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t               state_q, state_d;
    logic [ADDRESS-1:0]   addr_q;
    logic [ADDRESS-1:0]   remaining_q;
    logic [ADDRESS-1:0]   pend_base_q;
    logic [ADDRESS-1:0]   pend_words_q;
    logic                 drain_q;
    logic [BURSTLOG2-1:0] beat_q;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [FIFOLOG2-1:0]  wr_ptr_q, rd_ptr_q, rd_next;
    logic [FIFOLOG2:0]    count_q;
    logic [WIDTH-1:0]     head_q;

    logic                 load_now, defer, last_beat, fifo_push, fifo_pop;
    logic [ADDRESS-1:0]   words_rnd;

    assign words_rnd = {frame_words_i[ADDRESS-1:BURSTLOG2], {BURSTLOG2{1'b0}}};
    assign rd_next   = rd_ptr_q + PTR_ONE;
    assign fifo_pop  = pix_read_i && (count_q != '0) && !frame_start_i;

    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // A restart arriving while a request is accepted but not drained is deferred
    // until the old burst's strobes have all been counted.
    always_comb begin
        state_d   = state_q;
        load_now  = 1'b0;
        defer     = 1'b0;
        last_beat = 1'b0;
        fifo_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start_i)
                    load_now = 1'b1;
                else if (remaining_q >= BURST_A && (DEPTH_C - count_q) >= BURST_C)
                    state_d = REQ;
            end
            REQ: begin
                if (vid_rack_i) begin
                    state_d = DATA;
                    defer   = frame_start_i;
                end else if (frame_start_i) begin
                    state_d  = IDLE;
                    load_now = 1'b1;
                end
            end
            DATA: begin
                if (vid_ready_i) begin
                    fifo_push = !drain_q && !frame_start_i;
                    if (beat_q == LAST_BEAT) begin
                        last_beat = 1'b1;
                        state_d   = IDLE;
                    end
                end
                if (frame_start_i && !last_beat)
                    defer = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            addr_q       <= '0;
            remaining_q  <= '0;
            pend_base_q  <= '0;
            pend_words_q <= '0;
            drain_q      <= 1'b0;
            beat_q       <= '0;
        end else begin
            if (frame_start_i) begin
                pend_base_q  <= base_addr_i;
                pend_words_q <= words_rnd;
            end
            if (load_now) begin
                addr_q      <= base_addr_i;
                remaining_q <= words_rnd;
            end
            if (defer)
                drain_q <= 1'b1;
            if (last_beat) begin
                beat_q  <= '0;
                drain_q <= 1'b0;
                if (frame_start_i) begin
                    addr_q      <= base_addr_i;
                    remaining_q <= words_rnd;
                end else if (drain_q) begin
                    addr_q      <= pend_base_q;
                    remaining_q <= pend_words_q;
                end else begin
                    addr_q      <= addr_q + BURST_A;
                    remaining_q <= remaining_q - BURST_A;
                end
            end else if (state_q == DATA && vid_ready_i) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (fifo_push)
            mem[wr_ptr_q] <= vid_data_i;
    end

    // head_q always holds the word at rd_ptr_q, so the FIFO is first-word-fall-through.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (frame_start_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_push)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (fifo_pop)
                rd_ptr_q <= rd_next;
            case ({fifo_push, fifo_pop})
                2'b10:   count_q <= count_q + ONE_C;
                2'b01:   count_q <= count_q - ONE_C;
                default: count_q <= count_q;
            endcase
            if (fifo_push && (count_q == '0 || (count_q == ONE_C && fifo_pop)))
                head_q <= vid_data_i;
            else if (fifo_pop && count_q > ONE_C)
                head_q <= mem[rd_next];
        end
    end

    assign vid_read_o  = (state_q == REQ);
    assign vid_addr_o  = addr_q;
    assign busy_o      = (remaining_q != '0) || (state_q != IDLE) || drain_q;
    assign pix_data_o  = head_q;
    assign pix_empty_o = (count_q == '0);

`ifdef VID_FETCH_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clock_i) begin
        if (reset_i || frame_start_i)
            underrun_q <= 1'b0;
        else if (pix_read_i && count_q == '0 && busy_o)
            underrun_q <= 1'b1;
    end

    assign pix_underrun_o = underrun_q;
`else
    assign pix_underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_vid_fetch.sv
// tb/tb_vid_fetch.sv - directed self-checking bench for vid_fetch.
module tb_vid_fetch;

    localparam int WIDTH   = 32;
    localparam int ADDRESS = 21;
    localparam int BURST   = 4;
`ifdef VID_FETCH_UNDERRUN_EN
    localparam logic EXP_UR = 1'b1;
`else
    localparam logic EXP_UR = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_i = 1'b1;
    logic               frame_start_i = 1'b0;
    logic [ADDRESS-1:0] base_addr_i = '0;
    logic [ADDRESS-1:0] frame_words_i = '0;
    logic               busy_o;
    logic               vid_read_o;
    logic               vid_rack_i = 1'b0;
    logic               vid_ready_i = 1'b0;
    logic [ADDRESS-1:0] vid_addr_o;
    logic [WIDTH-1:0]   vid_data_i = '0;
    logic               pix_read_i = 1'b0;
    logic [WIDTH-1:0]   pix_data_o;
    logic               pix_empty_o;
    logic               pix_underrun_o;

    int total = 0;
    int bad   = 0;

    vid_fetch dut (
        .clock_i       (clk),
        .reset_i       (reset_i),
        .frame_start_i (frame_start_i),
        .base_addr_i   (base_addr_i),
        .frame_words_i (frame_words_i),
        .busy_o        (busy_o),
        .vid_read_o    (vid_read_o),
        .vid_rack_i    (vid_rack_i),
        .vid_ready_i   (vid_ready_i),
        .vid_addr_o    (vid_addr_o),
        .vid_data_i    (vid_data_i),
        .pix_read_i    (pix_read_i),
        .pix_data_o    (pix_data_o),
        .pix_empty_o   (pix_empty_o),
        .pix_underrun_o(pix_underrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mk(input logic [ADDRESS-1:0] a);
        return {11'h3A5, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [ADDRESS-1:0] base, input logic [ADDRESS-1:0] words);
        frame_start_i = 1'b1;
        base_addr_i   = base;
        frame_words_i = words;
        tick();
        frame_start_i = 1'b0;
    endtask

    task automatic wait_read();
        int n = 0;
        while (!vid_read_o && n < 50) begin
            tick();
            n++;
        end
        check("req_timeout", vid_read_o, 1);
    endtask

    task automatic strobe(input logic [ADDRESS-1:0] a);
        vid_ready_i = 1'b1;
        vid_data_i  = mk(a);
        tick();
        vid_ready_i = 1'b0;
    endtask

    task automatic serve(input int dly, input logic [ADDRESS-1:0] exp_addr);
        logic [ADDRESS-1:0] a;
        wait_read();
        a = vid_addr_o;
        check("req_addr", a, exp_addr);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("addr_hold", vid_addr_o, a);
            check("read_hold", vid_read_o, 1);
        end
        vid_rack_i = 1'b1;
        tick();
        vid_rack_i = 1'b0;
        check("read_drop", vid_read_o, 0);
        for (int i = 0; i < BURST; i++) begin
            vid_ready_i = 1'b1;
            vid_data_i  = mk(a + ADDRESS'(i));
            tick();
        end
        vid_ready_i = 1'b0;
    endtask

    task automatic pop_expect(input logic [ADDRESS-1:0] a);
        check("pop_not_empty", pix_empty_o, 0);
        check("pop_data", pix_data_o, mk(a));
        pix_read_i = 1'b1;
        tick();
        pix_read_i = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_read", vid_read_o, 0);
        check("rst_addr", vid_addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_empty", pix_empty_o, 1);
        check("rst_data", pix_data_o, 0);
        check("rst_underrun", pix_underrun_o, 0);
    endtask

    always @(negedge clk) begin
        if (!reset_i && dut.fifo_push)
            check("fifo_overflow", dut.count_q == 5'd16, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        reset_i = 1'b0;
        tick();
        check_reset_state();

        // 1: 16-word frame, rack after 2 cycles
        start_frame(21'h00100, 21'd16);
        check("t1_busy", busy_o, 1);
        for (int k = 0; k < 4; k++) begin
            serve(2, 21'h00100 + ADDRESS'(4 * k));
            if (k < 3) check("t1_busy_mid", busy_o, 1);
        end
        check("t1_busy_end", busy_o, 0);
        for (int i = 0; i < 16; i++) pop_expect(21'h00100 + ADDRESS'(i));
        check("t1_empty", pix_empty_o, 1);

        // 2: FIFO full stalls requests until space is freed
        start_frame(21'h00300, 21'd64);
        for (int k = 0; k < 4; k++) serve(0, 21'h00300 + ADDRESS'(4 * k));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_stall", vid_read_o, 0);
        end
        check("t2_busy", busy_o, 1);
        for (int i = 0; i < 4; i++) pop_expect(21'h00300 + ADDRESS'(i));
        serve(1, 21'h00310);

        // 5: push and pop together at count 5
        start_frame(21'h00400, 21'd8);
        check("t5_flushed", pix_empty_o, 1);
        serve(0, 21'h00400);
        wait_read();
        check("t5_addr", vid_addr_o, 21'h00404);
        vid_rack_i = 1'b1;
        tick();
        vid_rack_i = 1'b0;
        strobe(21'h00404);
        for (int i = 0; i < 3; i++) begin
            check("t5_head", pix_data_o, mk(21'h00400 + ADDRESS'(i)));
            pix_read_i = 1'b1;
            strobe(21'h00405 + ADDRESS'(i));
            pix_read_i = 1'b0;
        end
        for (int i = 3; i < 8; i++) pop_expect(21'h00400 + ADDRESS'(i));
        check("t5_empty", pix_empty_o, 1);

        // 3: restart mid-burst discards the rest of the open burst
        start_frame(21'h00500, 21'd16);
        wait_read();
        vid_rack_i = 1'b1;
        tick();
        vid_rack_i = 1'b0;
        strobe(21'h00500);
        check("t3_one_word", pix_empty_o, 0);
        start_frame(21'h00200, 21'd16);
        check("t3_flush", pix_empty_o, 1);
        check("t3_busy", busy_o, 1);
        check("t3_addr_old", vid_addr_o, 21'h00500);
        for (int i = 1; i < 4; i++) begin
            strobe(21'h00500 + ADDRESS'(i));
            check("t3_discard", pix_empty_o, 1);
            check("t3_no_read", vid_read_o, 0);
            if (i < 3) check("t3_addr_hold", vid_addr_o, 21'h00500);
        end
        check("t3_addr_new", vid_addr_o, 21'h00200);
        serve(0, 21'h00200);
        for (int i = 0; i < 4; i++) pop_expect(21'h00200 + ADDRESS'(i));

        // 4: address wraps at the top of the word space
        start_frame(21'h1FFFFC, 21'd8);
        serve(0, 21'h1FFFFC);
        serve(0, 21'h000000);
        for (int i = 0; i < 8; i++) pop_expect(21'h1FFFFC + ADDRESS'(i));
        check("t4_busy", busy_o, 0);

        // frame shorter than one burst: nothing fetched
        start_frame(21'h00700, 21'd3);
        check("short_busy", busy_o, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("short_no_read", vid_read_o, 0);
        end

        // 6: underrun flag, drop in REQ, reset mid-burst
        start_frame(21'h00600, 21'd8);
        check("t6_busy", busy_o, 1);
        pix_read_i = 1'b1;
        tick();
        pix_read_i = 1'b0;
        check("t6_ur_set", pix_underrun_o, EXP_UR);
        tick();
        check("t6_ur_hold", pix_underrun_o, EXP_UR);
        check("t6_in_req", vid_read_o, 1);
        start_frame(21'h00600, 21'd8);
        check("t6_req_drop", vid_read_o, 0);
        check("t6_ur_clear", pix_underrun_o, 0);
        wait_read();
        check("t6_addr", vid_addr_o, 21'h00600);
        vid_rack_i = 1'b1;
        tick();
        vid_rack_i = 1'b0;
        pix_read_i = 1'b1;
        tick();
        pix_read_i = 1'b0;
        check("t6_ur_data", pix_underrun_o, EXP_UR);
        strobe(21'h00600);
        reset_i     = 1'b1;
        vid_ready_i = 1'b1;
        tick();
        reset_i     = 1'b0;
        vid_ready_i = 1'b0;
        check_reset_state();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
